// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and a
// parity helper reused by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Expected parity bit for the low nbits of bits; odd selects odd parity.
  function automatic logic uart_parity(input logic [8:0] bits, input int nbits, input logic odd);
    logic acc;
    acc = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        acc = acc ^ bits[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side word port of uart_rx: data/valid/ready handshake plus status
// pulses. master = receiver, slave = consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data, valid, busy, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, busy, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both stages
// reset to RESET_VAL so a held-idle pin produces no spurious edge.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d;
  logic meta_q;
  logic sync_d;
  logic sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, LSB-first frames, stop-bit and
// optional parity check (`UART_RX_PARITY_EN), valid/ready word output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 busy_d, busy_q;
  logic                 frame_err_d, frame_err_q;
  logic                 parity_err_d, parity_err_q;
  logic                 overrun_d, overrun_q;
  logic                 rx_s;
  logic                 par_fail_s;

  uart_sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad_d, parity_bad_q;
  assign par_fail_s = parity_bad_q;
`else
  // No parity bit on the wire, so the check folds to a constant pass.
  assign par_fail_s = 1'b0 & uart_parity(9'(shift_q), DATA_BITS, 1'(PARITY_ODD));
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q & ~rx_if.ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (rx_s != UART_IDLE_LEVEL) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          idx_d = {IDX_W{1'b0}};
          // A start bit that is high again at mid-bit was only a glitch.
          if (rx_s == UART_IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = {CNT_W{1'b0}};
          parity_bad_d = rx_s ^ uart_parity(9'(shift_q), DATA_BITS, 1'(PARITY_ODD));
          state_d      = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s != UART_IDLE_LEVEL) begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end else if (par_fail_s) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_IDLE;
            // Load only into an empty slot or one being drained this cycle.
            if (!valid_q || rx_if.ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      shift_q      <= {DATA_BITS{1'b0}};
      data_q       <= {DATA_BITS{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.valid      = valid_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB  = DB + PB + 2;
  localparam int LAT = 3 + CPB / 2 + (DB + PB + 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .rx_if (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Monitor state, sampled on the falling edge and never cleared.
  logic [DB-1:0] got_q[$];
  int            rise_q[$];
  int            vcyc_cnt = 0, busy_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  logic          prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (bus.valid && !prev_valid) rise_q.push_back(cyc);
      vcyc_cnt <= vcyc_cnt + (bus.valid ? 1 : 0);
      busy_cnt <= busy_cnt + (bus.busy ? 1 : 0);
      fe_cnt   <= fe_cnt + (bus.frame_err ? 1 : 0);
      pe_cnt   <= pe_cnt + (bus.parity_err ? 1 : 0);
      ov_cnt   <= ov_cnt + (bus.overrun ? 1 : 0);
      prev_valid <= bus.valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic model_par(input logic [DB-1:0] d);
    return logic'($countones(d) % 2) ^ 1'(PODD);
  endfunction

  // 0 = good word, 1 = framing error, 2 = parity error
  function automatic int model_outcome(input logic [DB-1:0] d, input logic par, input logic stop);
    if (!stop) return 1;
    if (PB == 1 && par != model_par(d)) return 2;
    return 0;
  endfunction

  function automatic logic [DB+2:0] build(input logic [DB-1:0] d, input logic par, input logic stop);
    if (PB == 1) return {stop, par, d, 1'b0};
    else return {1'b1, stop, d, 1'b0};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop,
                            input int extra_low, output int t0);
    logic [DB+2:0] bits;
    bits = build(d, par, stop);
    step(1);
    t0 = cyc;
    for (int b = 0; b < FB; b++) begin
      rx = bits[b];
      step(CPB);
    end
    if (!stop) step(extra_low);
    rx = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.ready = 1'b1;
    step(3);
    checks++; if (bus.data !== 8'h00) $display("FAIL reset_data: got %0h want 0", bus.data); else passes++;
    checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); else passes++;
    checks++; if (bus.parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); else passes++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else passes++;
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    int gb, rb, vb, fb0, pb0, ob, t0, lat;
    bus.ready = 1'b1;
    gb = got_q.size(); rb = rise_q.size(); vb = vcyc_cnt; fb0 = fe_cnt; pb0 = pe_cnt; ob = ov_cnt;
    send_frame(8'hA5, model_par(8'hA5), 1'b1, 0, t0);
    step(CPB);
    checks++; if (got_q.size() - gb !== 1) $display("FAIL basic_count: got %0d want 1", got_q.size() - gb);
              else passes++;
    checks++; if (got_q.size() > gb && got_q[gb] !== 8'hA5) $display("FAIL basic_data: got %0h want a5", got_q[gb]);
              else passes++;
    checks++; if (vcyc_cnt - vb !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", vcyc_cnt - vb); else passes++;
    checks++; if ((fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob) !== 0)
                $display("FAIL basic_errors: got %0d pulses want 0", (fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob));
              else passes++;
    lat = (rise_q.size() == rb + 1) ? rise_q[rb] - t0 : -1;
    checks++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL basic_latency: got %0d want %0d +-1", lat, LAT);
              else passes++;
  endtask

  task automatic test_glitch();
    int rb, bb, fb0, pb0, ob;
    rb = rise_q.size(); bb = busy_cnt; fb0 = fe_cnt; pb0 = pe_cnt; ob = ov_cnt;
    step(1);
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(3 * CPB);
    checks++; if (busy_cnt - bb <= 0) $display("FAIL glitch_busy_rose: got %0d busy cycles want >0", busy_cnt - bb); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL glitch_busy_idle: got %b want 0", bus.busy); else passes++;
    checks++; if (rise_q.size() - rb !== 0) $display("FAIL glitch_no_valid: got %0d want 0", rise_q.size() - rb); else passes++;
    checks++; if ((fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob) !== 0)
                $display("FAIL glitch_errors: got %0d want 0", (fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob));
              else passes++;
  endtask

  task automatic test_break();
    int gb, fb0, pb0, ob, t0;
    bus.ready = 1'b1;
    gb = got_q.size(); fb0 = fe_cnt; pb0 = pe_cnt; ob = ov_cnt;
    send_frame(8'h3C, model_par(8'h3C), 1'b0, 40, t0);
    step(2 * CPB);
    send_frame(8'h81, model_par(8'h81), 1'b1, 0, t0);
    step(CPB);
    checks++; if (fe_cnt - fb0 !== 1) $display("FAIL break_frame_err: got %0d want 1", fe_cnt - fb0); else passes++;
    checks++; if (got_q.size() - gb !== 1) $display("FAIL break_count: got %0d want 1", got_q.size() - gb); else passes++;
    checks++; if (got_q.size() > gb && got_q[gb] !== 8'h81) $display("FAIL break_data: got %0h want 81", got_q[gb]);
              else passes++;
    checks++; if ((pe_cnt - pb0) + (ov_cnt - ob) !== 0)
                $display("FAIL break_other_errors: got %0d want 0", (pe_cnt - pb0) + (ov_cnt - ob));
              else passes++;
  endtask

  task automatic test_overrun();
    int gb, ob, fb0, t0;
    bus.ready = 1'b0;
    gb = got_q.size(); ob = ov_cnt; fb0 = fe_cnt;
    send_frame(8'h11, model_par(8'h11), 1'b1, 0, t0);
    step(CPB);
    send_frame(8'h22, model_par(8'h22), 1'b1, 0, t0);
    step(CPB);
    checks++; if (bus.valid !== 1'b1) $display("FAIL overrun_valid_held: got %b want 1", bus.valid); else passes++;
    checks++; if (bus.data !== 8'h11) $display("FAIL overrun_data_kept: got %0h want 11", bus.data); else passes++;
    checks++; if (ov_cnt - ob !== 1) $display("FAIL overrun_pulse: got %0d want 1", ov_cnt - ob); else passes++;
    checks++; if (fe_cnt - fb0 !== 0) $display("FAIL overrun_frame_err: got %0d want 0", fe_cnt - fb0); else passes++;
    bus.ready = 1'b1;
    step(1);
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0) $display("FAIL overrun_drain: got %b want 0", bus.valid); else passes++;
    checks++; if (got_q.size() - gb !== 1 || got_q[got_q.size() - 1] !== 8'h11)
                $display("FAIL overrun_consumed: got %0d words want one 11", got_q.size() - gb);
              else passes++;
    checks++; if (bus.data !== 8'h11) $display("FAIL overrun_data_stable: got %0h want 11", bus.data); else passes++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int gb, pb0, t0;
    bus.ready = 1'b1;
    gb = got_q.size(); pb0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1, 0, t0);
    step(CPB);
    checks++; if (pe_cnt - pb0 !== ((model_outcome(8'h07, 1'b0, 1'b1) == 2) ? 1 : 0))
                $display("FAIL parity_bad_pulse: got %0d want 1", pe_cnt - pb0);
              else passes++;
    checks++; if (got_q.size() - gb !== 0) $display("FAIL parity_bad_discard: got %0d want 0", got_q.size() - gb); else passes++;
    send_frame(8'h07, 1'b1, 1'b1, 0, t0);
    step(CPB);
    checks++; if (got_q.size() - gb !== 1 || got_q[got_q.size() - 1] !== 8'h07)
                $display("FAIL parity_good_data: got %0d words want one 07", got_q.size() - gb);
              else passes++;
    checks++; if (pe_cnt - pb0 !== 1) $display("FAIL parity_good_no_pulse: got %0d want 1 total", pe_cnt - pb0); else passes++;
  endtask
`endif

  task automatic test_reset_mid();
    int gb, fb0, pb0, ob, t0;
    logic [DB+2:0] bits;
    bus.ready = 1'b0;
    send_frame(8'h33, model_par(8'h33), 1'b1, 0, t0);
    step(CPB);
    bits = build(DB'($urandom), 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) begin
      rx = bits[b];
      step(CPB);
    end
    rx = bits[4];
    step(CPB / 2);
    checks++; if (bus.busy !== 1'b1 || bus.valid !== 1'b1)
                $display("FAIL rstmid_pre: got busy %b valid %b want 1 1", bus.busy, bus.valid);
              else passes++;
    rst = 1'b1;
    step(1);
    checks++; if (bus.valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.valid); else passes++;
    checks++; if (bus.data !== 8'h00) $display("FAIL rstmid_data: got %0h want 0", bus.data); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passes++;
    checks++; if ({bus.frame_err, bus.parity_err, bus.overrun} !== 3'b000)
                $display("FAIL rstmid_flags: got %b want 000", {bus.frame_err, bus.parity_err, bus.overrun});
              else passes++;
    rst = 1'b0;
    rx = 1'b1;
    bus.ready = 1'b1;
    step(2 * CPB);
    gb = got_q.size(); fb0 = fe_cnt; pb0 = pe_cnt; ob = ov_cnt;
    send_frame(8'h5A, model_par(8'h5A), 1'b1, 0, t0);
    step(CPB);
    checks++; if (got_q.size() - gb !== 1 || got_q[got_q.size() - 1] !== 8'h5A)
                $display("FAIL rstmid_next_frame: got %0d words want one 5a", got_q.size() - gb);
              else passes++;
    checks++; if ((fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob) !== 0)
                $display("FAIL rstmid_errors: got %0d want 0", (fe_cnt - fb0) + (pe_cnt - pb0) + (ov_cnt - ob));
              else passes++;
  endtask

  task automatic test_random();
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] d;
    logic          par, stop;
    int gb, vb, fb0, pb0, ob, t0, exp_fe, exp_pe, oc;
    bus.ready = 1'b1;
    gb = got_q.size(); vb = vcyc_cnt; fb0 = fe_cnt; pb0 = pe_cnt; ob = ov_cnt;
    exp_fe = 0; exp_pe = 0;
    for (int i = 0; i < 16; i++) begin
      d    = DB'($urandom_range(0, (1 << DB) - 1));
      stop = ($urandom_range(0, 4) != 0);
      par  = model_par(d) ^ ($urandom_range(0, 3) == 0);
      oc   = model_outcome(d, par, stop);
      if (oc == 0) exp_q.push_back(d);
      else if (oc == 1) exp_fe++;
      else exp_pe++;
      send_frame(d, par, stop, $urandom_range(0, 24), t0);
      step(CPB + $urandom_range(0, 7));
    end
    checks++; if (got_q.size() - gb !== exp_q.size())
                $display("FAIL rand_count: got %0d want %0d", got_q.size() - gb, exp_q.size());
              else passes++;
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++) begin
      checks++; if (got_q[gb + i] !== exp_q[i]) $display("FAIL rand_word%0d: got %0h want %0h", i, got_q[gb + i], exp_q[i]);
                else passes++;
    end
    checks++; if (fe_cnt - fb0 !== exp_fe) $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt - fb0, exp_fe); else passes++;
    checks++; if (pe_cnt - pb0 !== exp_pe) $display("FAIL rand_parity_err: got %0d want %0d", pe_cnt - pb0, exp_pe); else passes++;
    checks++; if (ov_cnt - ob !== 0) $display("FAIL rand_overrun: got %0d want 0", ov_cnt - ob); else passes++;
    checks++; if (vcyc_cnt - vb !== exp_q.size())
                $display("FAIL rand_valid_cycles: got %0d want %0d", vcyc_cnt - vb, exp_q.size());
              else passes++;
  endtask

  initial begin
    bus.ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
